countdown_ctrl: RTL and testbench

- Controller/sequencer for a W-bit synchronous down-counter datapath; owns the count register plus a run/pause/stop FSM and a tick prescaler.
- Loads a start value, decrements once per PRESCALE enabled cycles, and flags terminal count.
- Optionally auto-reloads to act as a periodic timer.
- Sits between the lab top level (switch/button inputs) and display/LED logic that consumes count, busy and done.

---
 rtl/countdown_ctrl.sv | 155 +++++++++++++++
 tb/tb_countdown_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// ---------------------------------------------------------------------------
// countdown_ctrl
//
// Purpose:
//   This block controls a W-bit synchronous down-counter. It holds the count
//   register, an IDLE/RUN/PAUSE state machine and a tick prescaler. A start
//   command loads a start value. The count then decrements once every
//   PRESCALE enabled cycles. A one-cycle done pulse marks terminal count.
//   When auto-reload is set, the block runs as a periodic timer.
//
// Parameters:
//   W          counter width in bits (>= 2)
//   PRESCALE   clock cycles per decrement (>= 1, 1 = every cycle)
//
// Ports:
//   i_clk       system clock, all state changes on the rising edge
//   i_rst       synchronous active-high reset
//   i_start     load i_load_val and run / restart / resume from pause
//   i_stop      abort to IDLE, count held
//   i_pause     freeze count and prescaler while running
//   i_reload    1 = auto-reload at terminal count, 0 = one-shot
//   i_load_val  start value, sampled on start and on auto-reload
//   o_count     current count (registered)
//   o_busy      1 while in RUN or PAUSE (registered)
//   o_done      one-cycle pulse on terminal count (registered)
//
// Command priority within a cycle: rst > stop > start > pause.
// ---------------------------------------------------------------------------
module countdown_ctrl #(
   parameter int W        = 4,
   parameter int PRESCALE = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic         i_stop,
   input  logic         i_pause,
   input  logic         i_reload,
   input  logic [W-1:0] i_load_val,
   output logic [W-1:0] o_count,
   output logic         o_busy,
   output logic         o_done
);

   // The prescaler needs at least one bit, even when PRESCALE == 1.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2
   } state_t;

   state_t          r_state;
   logic [W-1:0]    r_count;
   logic [PW-1:0]   r_presc;
   logic            r_busy;
   logic            r_done;

   logic            w_tick;       // this edge completes a prescale period
   logic            w_last;       // the next decrement reaches zero
   logic            w_zero_load;  // load value would start a zero-length run
   state_t          w_run_next;   // where RUN goes when it does not abort

   assign w_tick      = (r_presc == PS_LAST);
   assign w_last      = (r_count == W'(1));
   assign w_zero_load = (i_load_val == '0);
   assign w_run_next  = i_pause ? S_PAUSE : S_RUN;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_presc <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // In IDLE, stop and pause are ignored and the count holds.
               if (i_start) begin
                  if (w_zero_load) begin
                     // Zero-length run: report done at once, never go busy.
                     r_count <= '0;
                     r_done  <= 1'b1;
                  end else begin
                     r_count <= i_load_val;
                     r_presc <= '0;
                     r_state <= S_RUN;
                     r_busy  <= 1'b1;
                  end
               end
            end

            S_RUN: begin
               if (i_stop) begin
                  // Abort. This wins even over a terminal event on the same edge.
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else if (i_start) begin
                  r_count <= i_load_val;
                  r_presc <= '0;
               end else if (w_tick) begin
                  r_presc <= '0;
                  if (w_last) begin
                     // Terminal event. This branch intercepts the 1->0 step,
                     // so the count never underflows.
                     r_done <= 1'b1;
                     if (i_reload && !w_zero_load) begin
                        r_count <= i_load_val;
                        r_state <= w_run_next;
                     end else begin
                        // A one-shot end goes to IDLE even if pause is
                        // asserted on the same edge.
                        r_count <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     if (r_count != '0) begin
                        r_count <= r_count - W'(1);
                     end
                     r_state <= w_run_next;
                  end
               end else begin
                  r_presc <= r_presc + PW'(1);
                  r_state <= w_run_next;
               end
            end

            S_PAUSE: begin
               // Count and prescaler hold. Resume keeps the prescaler phase.
               if (i_stop) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else if (i_start) begin
                  r_state <= S_RUN;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_count = r_count;
   assign o_busy  = r_busy;
   assign o_done  = r_done;

endmodule

// File: tb/tb_countdown_ctrl.sv
// ---------------------------------------------------------------------------
// tb_countdown_ctrl
//
// Two instances share one stimulus stream: one with PRESCALE=1 and one with
// PRESCALE=4. A rule-level reference model tracks the mode, count and the
// number of cycles since the last decrement for each instance. After the
// directed scenarios, the bench applies a randomized command stream.
// ---------------------------------------------------------------------------
module tb_countdown_ctrl;

   localparam int W = 4;
   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_PAUSED = 2;

   logic         clk = 1'b0;
   logic         rst, start, stop, pause, reload;
   logic [W-1:0] load_val;
   logic [W-1:0] c1, c4;
   logic         b1, b4, d1, d4;

   int checks = 0;
   int errors = 0;

   // Reference model state: index 0 -> PRESCALE=1, index 1 -> PRESCALE=4.
   int ps_tab [2] = '{1, 4};
   int m_mode [2];
   int m_cnt  [2];
   int m_ph   [2];
   int m_done [2];

   // Constant expectations taken from the written scenarios.
   int s1_cnt  [6] = '{5, 4, 3, 2, 1, 0};
   int s1_busy [6] = '{1, 1, 1, 1, 1, 0};
   int s1_done [6] = '{0, 0, 0, 0, 0, 1};
   int s2_cnt  [9] = '{2, 2, 2, 2, 1, 1, 1, 1, 0};
   int s3_cnt  [9] = '{3, 2, 1, 3, 2, 1, 3, 2, 1};
   int s3_done [9] = '{0, 0, 0, 1, 0, 0, 1, 0, 0};

   always #5 clk = ~clk;

   countdown_ctrl #(.W(W), .PRESCALE(1)) u_p1 (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
      .i_pause(pause), .i_reload(reload), .i_load_val(load_val),
      .o_count(c1), .o_busy(b1), .o_done(d1)
   );

   countdown_ctrl #(.W(W), .PRESCALE(4)) u_p4 (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
      .i_pause(pause), .i_reload(reload), .i_load_val(load_val),
      .o_count(c4), .o_busy(b4), .o_done(d4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Apply the specification's rules to one edge of both model instances.
   task automatic model_update();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_mode[k] = M_IDLE; m_cnt[k] = 0; m_ph[k] = 0; m_done[k] = 0;
         end else begin
            m_done[k] = 0;
            if (m_mode[k] == M_IDLE) begin
               if (start) begin
                  if (load_val == 0) begin
                     m_cnt[k] = 0; m_done[k] = 1;
                  end else begin
                     m_cnt[k] = int'(load_val); m_ph[k] = 0; m_mode[k] = M_RUN;
                  end
               end
            end else if (m_mode[k] == M_RUN) begin
               if (stop) begin
                  m_mode[k] = M_IDLE;
               end else if (start) begin
                  m_cnt[k] = int'(load_val); m_ph[k] = 0;
               end else begin
                  int nm;
                  nm = pause ? M_PAUSED : M_RUN;
                  if (m_ph[k] == ps_tab[k] - 1) begin
                     m_ph[k] = 0;
                     if (m_cnt[k] == 1) begin
                        m_done[k] = 1;
                        if (reload && load_val != 0) begin
                           m_cnt[k] = int'(load_val); m_mode[k] = nm;
                        end else begin
                           m_cnt[k] = 0; m_mode[k] = M_IDLE;
                        end
                     end else begin
                        m_cnt[k] = m_cnt[k] - 1; m_mode[k] = nm;
                     end
                  end else begin
                     m_ph[k] = m_ph[k] + 1; m_mode[k] = nm;
                  end
               end
            end else begin
               if (stop)       m_mode[k] = M_IDLE;
               else if (start) m_mode[k] = M_RUN;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/p1_count"}, 32'(c1), 32'(m_cnt[0]));
      chk({tag, "/p1_busy"},  32'(b1), 32'(m_mode[0] != M_IDLE));
      chk({tag, "/p1_done"},  32'(d1), 32'(m_done[0]));
      chk({tag, "/p4_count"}, 32'(c4), 32'(m_cnt[1]));
      chk({tag, "/p4_busy"},  32'(b4), 32'(m_mode[1] != M_IDLE));
      chk({tag, "/p4_done"},  32'(d4), 32'(m_done[1]));
   endtask

   // One clock edge: update the model on the edge, then sample 1 time unit later.
   task automatic step(input string tag);
      @(posedge clk);
      model_update();
      #1;
      check_all(tag);
      $display("step %-10s rst=%0b st=%0b sp=%0b pa=%0b rl=%0b lv=%0d | p1 c=%0d b=%0b d=%0b | p4 c=%0d b=%0b d=%0b",
               tag, rst, start, stop, pause, reload, load_val, c1, b1, d1, c4, b4, d4);
   endtask

   task automatic drive(input logic r, input logic st, input logic sp, input logic pa);
      rst = r; start = st; stop = sp; pause = pa;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = M_IDLE; m_cnt[k] = 0; m_ph[k] = 0; m_done[k] = 0;
      end
      drive(1, 0, 0, 0); reload = 0; load_val = '0;

      // Reset state
      step("reset");
      step("reset");
      chk("reset/count_const", 32'(c1), 32'd0);
      chk("reset/busy_const",  32'(b4), 32'd0);

      // One-shot run with PRESCALE=1: 5,4,3,2,1,0
      drive(0, 1, 0, 0); reload = 0; load_val = 4'd5;
      for (int i = 0; i < 6; i++) begin
         step("oneshot5");
         chk("oneshot5/count_const", 32'(c1), 32'(s1_cnt[i]));
         chk("oneshot5/busy_const",  32'(b1), 32'(s1_busy[i]));
         chk("oneshot5/done_const",  32'(d1), 32'(s1_done[i]));
         start = 0;
      end
      for (int i = 0; i < 18; i++) step("drain");

      // PRESCALE=4 with load 2: terminal after edge 8
      drive(0, 1, 0, 0); load_val = 4'd2;
      for (int i = 0; i < 9; i++) begin
         step("presc4");
         chk("presc4/count_const", 32'(c4), 32'(s2_cnt[i]));
         chk("presc4/done_const",  32'(d4), 32'(i == 8));
         start = 0;
      end
      step("presc4_end");
      chk("presc4/idle_const", 32'(b4), 32'd0);

      // Auto-reload with load 3, then stop freezes the count
      drive(0, 1, 0, 0); reload = 1; load_val = 4'd3;
      for (int i = 0; i < 9; i++) begin
         step("reload3");
         chk("reload3/count_const", 32'(c1), 32'(s3_cnt[i]));
         chk("reload3/done_const",  32'(d1), 32'(s3_done[i]));
         chk("reload3/busy_const",  32'(b1), 32'd1);
         start = 0;
      end
      drive(0, 0, 1, 0);
      step("stop");
      chk("stop/frozen_const", 32'(c1), 32'd1);
      drive(0, 0, 0, 0);
      step("idle_hold");
      step("idle_hold");
      reload = 0;

      // Pause for 4 cycles mid-run, then resume and run to completion
      drive(0, 1, 0, 0); load_val = 4'd9;
      step("pause_run");
      start = 0;
      for (int i = 0; i < 3; i++) step("pause_run");
      pause = 1;
      for (int i = 0; i < 4; i++) step("pause_hold");
      drive(0, 1, 0, 0);
      step("resume");
      start = 0;
      for (int i = 0; i < 40; i++) step("resume");

      // Stop on the terminal edge
      drive(0, 1, 0, 0); load_val = 4'd3;
      step("term_stop");
      start = 0;
      step("term_stop");
      step("term_stop");
      chk("term_stop/pre_const", 32'(c1), 32'd1);
      stop = 1;
      step("term_stop");
      chk("term_stop/count_const", 32'(c1), 32'd1);
      chk("term_stop/done_const",  32'(d1), 32'd0);
      chk("term_stop/busy_const",  32'(b1), 32'd0);
      stop = 0;

      // start and pause together while running: restart, stay in RUN
      drive(0, 1, 0, 0); load_val = 4'd6;
      step("st_pa");
      start = 0;
      step("st_pa");
      step("st_pa");
      drive(0, 1, 0, 1); load_val = 4'd8;
      step("st_pa");
      chk("st_pa/count_const", 32'(c1), 32'd8);
      drive(0, 0, 0, 0);
      step("st_pa");
      chk("st_pa/running_const", 32'(c1), 32'd7);

      // Zero-length run from IDLE
      drive(0, 0, 1, 0);
      step("zl_prep");
      drive(0, 1, 0, 0); load_val = 4'd0;
      step("zero_len");
      chk("zero_len/done_const", 32'(d1), 32'd1);
      chk("zero_len/busy_const", 32'(b1), 32'd0);
      chk("zero_len/count_const", 32'(c4), 32'd0);
      start = 0;
      step("zero_len");

      // Reset mid-run at count 7, then a normal start
      drive(0, 1, 0, 0); load_val = 4'd9;
      step("rst_mid");
      start = 0;
      step("rst_mid");
      step("rst_mid");
      chk("rst_mid/pre_const", 32'(c1), 32'd7);
      drive(1, 1, 1, 1);
      step("rst_mid");
      chk("rst_mid/count_const", 32'(c1), 32'd0);
      chk("rst_mid/busy_const",  32'(b1), 32'd0);
      drive(0, 1, 0, 0); load_val = 4'd4;
      step("rst_after");
      chk("rst_after/count_const", 32'(c1), 32'd4);
      start = 0;

      // Randomized command stream against the reference model
      for (int i = 0; i < 400; i++) begin
         rst      = ($urandom_range(0, 99) == 0);
         start    = ($urandom_range(0, 14) == 0);
         stop     = ($urandom_range(0, 29) == 0);
         pause    = ($urandom_range(0, 7) == 0);
         reload   = ($urandom_range(0, 1) == 1);
         load_val = ($urandom_range(0, 5) == 0) ? 4'd0 : W'($urandom_range(1, 15));
         step("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
